// File: rtl/gray_step_sched.sv
// Command-driven Gray-code stepper: runs N single-bit-change steps per command,
// reporting which bit flipped and whether the binary counter wrapped.
module gray_step_sched #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 8,
  localparam int IDX_W     = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_clear,
  input  logic                  cmd_dir,
  input  logic [CNT_WIDTH-1:0]  cmd_steps,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  step_pulse,
  output logic [IDX_W-1:0]      flip_idx,
  output logic                  wrapped,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] bin;
  logic [DATA_WIDTH-1:0] bin_next;
  logic [DATA_WIDTH-1:0] probe;
  logic [CNT_WIDTH-1:0]  remaining;
  logic                  dir;
  logic                  wrap_next;
  logic [IDX_W-1:0]      idx_next;
  logic                  found;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  assign bin_next  = dir ? bin - DATA_WIDTH'(1) : bin + DATA_WIDTH'(1);
  // Counting down flips at the trailing zeros, so inverting lets one
  // trailing-ones search serve both directions.
  assign probe     = dir ? ~bin : bin;
  assign wrap_next = &probe;

  always_comb begin
    idx_next = IDX_W'(DATA_WIDTH - 1);
    found    = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (!found && !probe[i]) begin
        idx_next = IDX_W'(i);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bin        <= '0;
      out        <= '0;
      remaining  <= '0;
      dir        <= 1'b0;
      step_pulse <= 1'b0;
      wrapped    <= 1'b0;
      flip_idx   <= '0;
      done       <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      wrapped    <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_clear) begin
              bin   <= '0;
              out   <= '0;
              state <= DONE;
              done  <= 1'b1;
            end else if (cmd_steps == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              dir       <= cmd_dir;
              remaining <= cmd_steps;
              state     <= RUN;
            end
          end
        end
        RUN: begin
          bin        <= bin_next;
          out        <= bin_next ^ (bin_next >> 1);
          step_pulse <= 1'b1;
          wrapped    <= wrap_next;
          flip_idx   <= idx_next;
          remaining  <= remaining - CNT_WIDTH'(1);
          // done lands with the final step_pulse
          if (remaining == CNT_WIDTH'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_step_sched.sv
// Directed bench for gray_step_sched (DATA_WIDTH=4, CNT_WIDTH=8).
module tb_gray_step_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_clear, cmd_dir;
  logic [7:0] cmd_steps;
  logic [3:0] out;
  logic       step_pulse, wrapped, busy, done;
  logic [1:0] flip_idx;

  int checks = 0;
  int errors = 0;

  gray_step_sched #(.DATA_WIDTH(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_clear(cmd_clear),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
    .out(out), .step_pulse(step_pulse), .flip_idx(flip_idx),
    .wrapped(wrapped), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for exactly one accepting edge; returns 1ns after edge k.
  task automatic send(input logic clr, input logic d, input logic [7:0] n);
    cmd_clear = clr;
    cmd_dir   = d;
    cmd_steps = n;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Standard 4-bit Gray sequence starting after 0.
  logic [3:0] seq16 [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                             4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
  logic [3:0] up4_out  [4] = '{4'h1, 4'h3, 4'h2, 4'h6};
  logic [1:0] up4_flip [4] = '{2'd0, 2'd1, 2'd0, 2'd2};
  logic [3:0] held_out [5] = '{4'h2, 4'h6, 4'h7, 4'h5, 4'h4};

  initial begin
    logic [3:0] prev;
    logic [3:0] diff;
    int         fidx;

    reset = 1'b1; cmd_valid = 1'b0; cmd_clear = 1'b0; cmd_dir = 1'b0; cmd_steps = '0;
    repeat (2) tick();
    chk("rst_out", out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_pulse", step_pulse, 0);
    chk("rst_flip", flip_idx, 0);
    reset = 1'b0;
    tick();

    // Up 4 from reset
    send(1'b0, 1'b0, 8'd4);
    chk("up4_busy0", busy, 1);
    chk("up4_ready0", cmd_ready, 0);
    chk("up4_pulse0", step_pulse, 0);
    chk("up4_out0", out, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("up4_out", out, up4_out[i]);
      chk("up4_pulse", step_pulse, 1);
      chk("up4_flip", flip_idx, up4_flip[i]);
      chk("up4_wrap", wrapped, 0);
      chk("up4_busy", busy, 1);
      chk("up4_done", done, (i == 3) ? 1 : 0);
    end
    tick();
    chk("up4_idle_busy", busy, 0);
    chk("up4_idle_done", done, 0);
    chk("up4_idle_pulse", step_pulse, 0);
    chk("up4_hold_out", out, 4'h6);

    // Clear back to 0
    send(1'b1, 1'b0, 8'd9);
    chk("clr_out", out, 0);
    chk("clr_done", done, 1);
    chk("clr_pulse", step_pulse, 0);
    tick();
    chk("clr_idle", busy, 0);

    // Full wrap, up 16
    send(1'b0, 1'b0, 8'd16);
    prev = 4'h0;
    for (int i = 0; i < 16; i++) begin
      tick();
      diff = out ^ prev;
      fidx = 0;
      for (int b = 0; b < 4; b++) if (diff[b]) fidx = b;
      chk("w16_out", out, seq16[i]);
      chk("w16_onebit", $countones(diff), 1);
      chk("w16_flip", flip_idx, fidx);
      chk("w16_pulse", step_pulse, 1);
      chk("w16_wrap", wrapped, (i == 15) ? 1 : 0);
      chk("w16_done", done, (i == 15) ? 1 : 0);
      prev = out;
    end
    chk("w16_flip_last", flip_idx, 3);
    tick();

    // Down 1 from 0 wraps to 1000
    send(1'b0, 1'b1, 8'd1);
    tick();
    chk("dn1_out", out, 4'h8);
    chk("dn1_wrap", wrapped, 1);
    chk("dn1_flip", flip_idx, 3);
    chk("dn1_done", done, 1);
    chk("dn1_pulse", step_pulse, 1);
    tick();
    chk("dn1_idle", busy, 0);
    chk("dn1_wrap_clr", wrapped, 0);

    // Zero-step command
    send(1'b0, 1'b0, 8'd0);
    chk("z_done", done, 1);
    chk("z_pulse", step_pulse, 0);
    chk("z_out", out, 4'h8);
    chk("z_busy", busy, 1);
    tick();
    chk("z_idle", busy, 0);
    chk("z_done_off", done, 0);

    // Up 3 from bin 15 -> 0,1,2, then clear
    send(1'b0, 1'b0, 8'd3);
    repeat (3) tick();
    chk("u3_out", out, 4'h3);
    tick();
    send(1'b1, 1'b0, 8'd0);
    chk("clr2_out", out, 0);
    chk("clr2_pulse", step_pulse, 0);
    chk("clr2_done", done, 1);
    tick();

    // Held cmd_valid with changed steps during RUN
    cmd_clear = 1'b0; cmd_dir = 1'b0; cmd_steps = 8'd2; cmd_valid = 1'b1;
    tick();
    cmd_steps = 8'd5;
    tick();
    chk("held_s1", out, 4'h1);
    tick();
    chk("held_s2", out, 4'h3);
    chk("held_done", done, 1);
    chk("held_ready_done", cmd_ready, 0);
    tick();
    chk("held_idle", busy, 0);
    chk("held_ready", cmd_ready, 1);
    chk("held_out_kept", out, 4'h3);
    tick();
    cmd_valid = 1'b0;
    chk("held_accept", busy, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("held2_out", out, held_out[i]);
      chk("held2_done", done, (i == 4) ? 1 : 0);
    end
    tick();

    // Async reset mid-RUN
    send(1'b0, 1'b0, 8'd10);
    repeat (2) tick();
    chk("ar_pre_out", out, 4'hD);
    #3 reset = 1'b1;
    #1;
    chk("ar_out", out, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ready", cmd_ready, 1);
    chk("ar_done", done, 0);
    chk("ar_pulse", step_pulse, 0);
    #1 reset = 1'b0;
    tick();
    chk("ar_post_busy", busy, 0);
    chk("ar_post_done", done, 0);
    chk("ar_post_out", out, 0);
    send(1'b0, 1'b0, 8'd1);
    tick();
    chk("ar_resume_out", out, 4'h1);
    chk("ar_resume_done", done, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
